// File: rtl/gon_seq_pkg.sv
// Shared types and defaults for the GON gather-path sequencer.
// Fallback values for the global array-geometry defines, used only when no project header set them.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 3
`endif
`ifndef NUMS_PE_ROW
`define NUMS_PE_ROW 2
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 2
`endif

package gon_seq_pkg;

   typedef enum logic [1:0] {
      GS_IDLE  = 2'd0,
      GS_CFG   = 2'd1,
      GS_DRAIN = 2'd2,
      GS_DONE  = 2'd3
   } gs_state_t;

   localparam int BEAT_W_DEFAULT = 16;

endpackage

// File: rtl/gon_id_shifter.sv
// One ID scan-chain feeder: stream ready, shift counter, registered set/scan_in toward the GON.
module gon_id_shifter
   import gon_seq_pkg::*;
#(
   parameter int W   = 4,
   parameter int LEN = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic         valid,
   input  logic [W-1:0] data,
   output logic         ready,
   output logic         done_next,
   output logic         set,
   output logic [W-1:0] scan_in
);

   localparam int CW = $clog2(LEN + 1);
   localparam logic [CW-1:0] LEN_C  = CW'(LEN);
   localparam logic [CW-1:0] LAST_C = CW'(LEN - 1);

   logic [CW-1:0] cnt;
   logic          accept;

   assign ready  = enable && (cnt < LEN_C);
   assign accept = valid && ready;
   // Look ahead so the controller can leave CFG on the edge that takes the final ID.
   assign done_next = (cnt == LEN_C) || (accept && (cnt == LAST_C));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         set     <= 1'b0;
         scan_in <= '0;
      end else begin
         set <= accept;
         if (accept) begin
            scan_in <= data;
            cnt     <= cnt + CW'(1);
         end
         if (clear) begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/gon_sequencer.sv
// GON gather-path controller: configures the X/Y ID chains, then walks tags while counting GON->GLB beats.
module gon_sequencer
   import gon_seq_pkg::*;
#(
   parameter int X_SCAN_LEN = `NUMS_PE_ROW * `NUMS_PE_COL,
   parameter int Y_SCAN_LEN = `NUMS_PE_ROW,
   parameter int BEAT_W     = BEAT_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_start,
   input  logic                 xid_valid,
   output logic                 xid_ready,
   input  logic [`XID_BITS-1:0] xid_data,
   input  logic                 yid_valid,
   output logic                 yid_ready,
   input  logic [`YID_BITS-1:0] yid_data,
   output logic                 set_XID,
   output logic [`XID_BITS-1:0] XID_scan_in,
   output logic                 set_YID,
   output logic [`YID_BITS-1:0] YID_scan_in,
   input  logic                 drain_start,
   input  logic [`XID_BITS:0]   num_x,
   input  logic [`YID_BITS:0]   num_y,
   input  logic [BEAT_W-1:0]    beats,
   output logic [`XID_BITS-1:0] tag_X,
   output logic [`YID_BITS-1:0] tag_Y,
   input  logic                 GON_valid,
   input  logic                 GON_ready,
   output logic                 busy,
   output logic                 cfg_done,
   output logic                 drain_done
);

   localparam int XB = `XID_BITS;
   localparam int YB = `YID_BITS;

   gs_state_t         state;
   logic [XB:0]       num_x_r;
   logic [YB:0]       num_y_r;
   logic [BEAT_W-1:0] beats_r;
   logic [BEAT_W-1:0] beat_cnt;

   logic cfg_clear;
   logic cfg_en;
   logic x_done_next;
   logic y_done_next;
   logic beat;
   logic zero_extent;
   logic last_beat;
   logic last_x;
   logic last_y;

   assign cfg_clear   = (state == GS_IDLE) && cfg_start;
   assign cfg_en      = (state == GS_CFG);
   assign beat        = GON_valid && GON_ready;
   assign zero_extent = (num_x_r == '0) || (num_y_r == '0) || (beats_r == '0);
   // Full-width compares so num_x == 2^XID_BITS still terminates the inner loop.
   assign last_beat   = (beat_cnt == beats_r - BEAT_W'(1));
   assign last_x      = ({1'b0, tag_X} == num_x_r - (XB+1)'(1));
   assign last_y      = ({1'b0, tag_Y} == num_y_r - (YB+1)'(1));

   gon_id_shifter #(.W(XB), .LEN(X_SCAN_LEN)) u_x_shifter (
      .clk       (clk),
      .rst       (rst),
      .clear     (cfg_clear),
      .enable    (cfg_en),
      .valid     (xid_valid),
      .data      (xid_data),
      .ready     (xid_ready),
      .done_next (x_done_next),
      .set       (set_XID),
      .scan_in   (XID_scan_in)
   );

   gon_id_shifter #(.W(YB), .LEN(Y_SCAN_LEN)) u_y_shifter (
      .clk       (clk),
      .rst       (rst),
      .clear     (cfg_clear),
      .enable    (cfg_en),
      .valid     (yid_valid),
      .data      (yid_data),
      .ready     (yid_ready),
      .done_next (y_done_next),
      .set       (set_YID),
      .scan_in   (YID_scan_in)
   );

   // Phase control; busy and the done pulses are registered alongside the state they decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= GS_IDLE;
         busy       <= 1'b0;
         cfg_done   <= 1'b0;
         drain_done <= 1'b0;
         tag_X      <= '0;
         tag_Y      <= '0;
         beat_cnt   <= '0;
         num_x_r    <= '0;
         num_y_r    <= '0;
         beats_r    <= '0;
      end else begin
         cfg_done   <= 1'b0;
         drain_done <= 1'b0;
         case (state)
            GS_IDLE: begin
               if (cfg_start) begin
                  state <= GS_CFG;
                  busy  <= 1'b1;
               end else if (drain_start) begin
                  state    <= GS_DRAIN;
                  busy     <= 1'b1;
                  num_x_r  <= num_x;
                  num_y_r  <= num_y;
                  beats_r  <= beats;
                  tag_X    <= '0;
                  tag_Y    <= '0;
                  beat_cnt <= '0;
               end
            end
            GS_CFG: begin
               if (x_done_next && y_done_next) begin
                  state    <= GS_DONE;
                  busy     <= 1'b0;
                  cfg_done <= 1'b1;
               end
            end
            GS_DRAIN: begin
               if (zero_extent) begin
                  state      <= GS_DONE;
                  busy       <= 1'b0;
                  drain_done <= 1'b1;
               end else if (beat) begin
                  if (last_beat) begin
                     beat_cnt <= '0;
                     if (last_x && last_y) begin
                        state      <= GS_DONE;
                        busy       <= 1'b0;
                        drain_done <= 1'b1;
                     end else if (last_x) begin
                        tag_X <= '0;
                        tag_Y <= tag_Y + YB'(1);
                     end else begin
                        tag_X <= tag_X + XB'(1);
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            GS_DONE: begin
               state <= GS_IDLE;
            end
            default: begin
               state <= GS_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gon_sequencer.sv
// Directed self-checking bench for gon_sequencer: reset, stalled config, drains, zero extent, start collision.
module tb_gon_sequencer;

   localparam int XB = `XID_BITS;
   localparam int YB = `YID_BITS;
   localparam int BW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_start;
   logic          xid_valid;
   logic          xid_ready;
   logic [XB-1:0] xid_data;
   logic          yid_valid;
   logic          yid_ready;
   logic [YB-1:0] yid_data;
   logic          set_XID;
   logic [XB-1:0] XID_scan_in;
   logic          set_YID;
   logic [YB-1:0] YID_scan_in;
   logic          drain_start;
   logic [XB:0]   num_x;
   logic [YB:0]   num_y;
   logic [BW-1:0] beats;
   logic [XB-1:0] tag_X;
   logic [YB-1:0] tag_Y;
   logic          GON_valid;
   logic          GON_ready;
   logic          busy;
   logic          cfg_done;
   logic          drain_done;

   int checks = 0;
   int errors = 0;

   gon_sequencer #(.X_SCAN_LEN(4), .Y_SCAN_LEN(2), .BEAT_W(BW)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_start   (cfg_start),
      .xid_valid   (xid_valid),
      .xid_ready   (xid_ready),
      .xid_data    (xid_data),
      .yid_valid   (yid_valid),
      .yid_ready   (yid_ready),
      .yid_data    (yid_data),
      .set_XID     (set_XID),
      .XID_scan_in (XID_scan_in),
      .set_YID     (set_YID),
      .YID_scan_in (YID_scan_in),
      .drain_start (drain_start),
      .num_x       (num_x),
      .num_y       (num_y),
      .beats       (beats),
      .tag_X       (tag_X),
      .tag_Y       (tag_Y),
      .GON_valid   (GON_valid),
      .GON_ready   (GON_ready),
      .busy        (busy),
      .cfg_done    (cfg_done),
      .drain_done  (drain_done)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs set before the call are sampled on that edge, outputs read 1 ns later.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " set_XID"}, 32'(set_XID), 0);
      checkOutput({tag, " XID_scan_in"}, 32'(XID_scan_in), 0);
      checkOutput({tag, " set_YID"}, 32'(set_YID), 0);
      checkOutput({tag, " YID_scan_in"}, 32'(YID_scan_in), 0);
      checkOutput({tag, " tag_X"}, 32'(tag_X), 0);
      checkOutput({tag, " tag_Y"}, 32'(tag_Y), 0);
      checkOutput({tag, " xid_ready"}, 32'(xid_ready), 0);
      checkOutput({tag, " yid_ready"}, 32'(yid_ready), 0);
      checkOutput({tag, " busy"}, 32'(busy), 0);
      checkOutput({tag, " cfg_done"}, 32'(cfg_done), 0);
      checkOutput({tag, " drain_done"}, 32'(drain_done), 0);
   endtask

   // Config table: inputs driven in cycle i, outputs expected one cycle later.
   typedef struct {
      logic          xv;
      logic [XB-1:0] xd;
      logic          yv;
      logic [YB-1:0] yd;
      logic          sx;
      logic [XB-1:0] xs;
      logic          sy;
      logic [YB-1:0] ys;
      logic          cd;
      logic          bz;
   } cfg_row_t;

   cfg_row_t cfgTab [8];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int mx, my, mb, nbeats, cycles, cfgPulses, drainPulses;
      bit finished;

      cfgTab[0] = '{1'b1, 4'd1, 1'b1, 3'd0, 1'b1, 4'd1, 1'b1, 3'd0, 1'b0, 1'b1};
      cfgTab[1] = '{1'b0, 4'd0, 1'b1, 3'd1, 1'b0, 4'd1, 1'b1, 3'd1, 1'b0, 1'b1};
      cfgTab[2] = '{1'b1, 4'd2, 1'b1, 3'd7, 1'b1, 4'd2, 1'b0, 3'd1, 1'b0, 1'b1};
      cfgTab[3] = '{1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd2, 1'b0, 3'd1, 1'b0, 1'b1};
      cfgTab[4] = '{1'b1, 4'd3, 1'b0, 3'd0, 1'b1, 4'd3, 1'b0, 3'd1, 1'b0, 1'b1};
      cfgTab[5] = '{1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd3, 1'b0, 3'd1, 1'b0, 1'b1};
      cfgTab[6] = '{1'b1, 4'd4, 1'b0, 3'd0, 1'b1, 4'd4, 1'b0, 3'd1, 1'b1, 1'b0};
      cfgTab[7] = '{1'b1, 4'd9, 1'b0, 3'd0, 1'b0, 4'd4, 1'b0, 3'd1, 1'b0, 1'b0};

      rst = 1'b1; cfg_start = 1'b0; drain_start = 1'b0;
      xid_valid = 1'b0; xid_data = '0; yid_valid = 1'b0; yid_data = '0;
      num_x = '0; num_y = '0; beats = '0; GON_valid = 1'b0; GON_ready = 1'b0;

      // Reset
      applyStimulus();
      applyStimulus();
      checkAllZero("reset");
      rst = 1'b0;
      applyStimulus();

      // Configuration with xid bubbles on alternate cycles
      cfg_start = 1'b1;
      applyStimulus();
      cfg_start = 1'b0;
      checkOutput("cfg entry xid_ready", 32'(xid_ready), 1);
      checkOutput("cfg entry yid_ready", 32'(yid_ready), 1);
      checkOutput("cfg entry busy", 32'(busy), 1);
      for (int i = 0; i < 8; i++) begin
         xid_valid = cfgTab[i].xv; xid_data = cfgTab[i].xd;
         yid_valid = cfgTab[i].yv; yid_data = cfgTab[i].yd;
         applyStimulus();
         checkOutput($sformatf("cfg[%0d] set_XID", i), 32'(set_XID), 32'(cfgTab[i].sx));
         checkOutput($sformatf("cfg[%0d] XID_scan_in", i), 32'(XID_scan_in), 32'(cfgTab[i].xs));
         checkOutput($sformatf("cfg[%0d] set_YID", i), 32'(set_YID), 32'(cfgTab[i].sy));
         checkOutput($sformatf("cfg[%0d] YID_scan_in", i), 32'(YID_scan_in), 32'(cfgTab[i].ys));
         checkOutput($sformatf("cfg[%0d] cfg_done", i), 32'(cfg_done), 32'(cfgTab[i].cd));
         checkOutput($sformatf("cfg[%0d] busy", i), 32'(busy), 32'(cfgTab[i].bz));
      end
      xid_valid = 1'b0; yid_valid = 1'b0;
      checkOutput("cfg idle xid_ready", 32'(xid_ready), 0);

      // Drain 2x2x3 with random backpressure
      num_x = 5'd2; num_y = 4'd2; beats = 16'd3; drain_start = 1'b1;
      applyStimulus();
      drain_start = 1'b0;
      checkOutput("drain entry busy", 32'(busy), 1);
      mx = 0; my = 0; mb = 0; nbeats = 0; finished = 1'b0;
      for (cycles = 0; cycles < 300 && !finished; cycles++) begin
         GON_valid = 1'b1;
         GON_ready = 1'($urandom_range(0, 1));
         checkOutput("drain tag_X", 32'(tag_X), 32'(mx));
         checkOutput("drain tag_Y", 32'(tag_Y), 32'(my));
         checkOutput("drain early drain_done", 32'(drain_done), 0);
         applyStimulus();
         if (GON_ready) begin
            nbeats++;
            mb++;
            if (mb == 3) begin
               mb = 0;
               if (mx == 1 && my == 1) finished = 1'b1;
               else if (mx == 1) begin mx = 0; my++; end
               else mx++;
            end
         end
      end
      checkOutput("drain completed within budget", 32'(finished), 1);
      checkOutput("drain beat total", 32'(nbeats), 12);
      checkOutput("drain drain_done", 32'(drain_done), 1);
      checkOutput("drain done busy", 32'(busy), 0);
      checkOutput("drain final tag_X", 32'(tag_X), 1);
      checkOutput("drain final tag_Y", 32'(tag_Y), 1);
      GON_valid = 1'b0; GON_ready = 1'b0;
      applyStimulus();
      checkOutput("drain_done single pulse", 32'(drain_done), 0);

      // Zero extent: beats = 0 completes with no tag movement
      beats = 16'd0; GON_valid = 1'b1; GON_ready = 1'b1; drain_start = 1'b1;
      applyStimulus();
      drain_start = 1'b0;
      checkOutput("zero +1 drain_done", 32'(drain_done), 0);
      applyStimulus();
      checkOutput("zero +2 drain_done", 32'(drain_done), 1);
      checkOutput("zero tag_X", 32'(tag_X), 0);
      checkOutput("zero tag_Y", 32'(tag_Y), 0);
      applyStimulus();

      // Simultaneous starts: configuration wins
      beats = 16'd3; cfg_start = 1'b1; drain_start = 1'b1;
      applyStimulus();
      cfg_start = 1'b0; drain_start = 1'b0;
      checkOutput("collide xid_ready", 32'(xid_ready), 1);
      xid_valid = 1'b1; yid_valid = 1'b1; xid_data = 4'd5; yid_data = 3'd2;
      cfgPulses = 0; drainPulses = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus();
         if (cfg_done) cfgPulses++;
         if (drain_done) drainPulses++;
      end
      xid_valid = 1'b0; yid_valid = 1'b0;
      checkOutput("collide cfg_done pulses", 32'(cfgPulses), 1);
      checkOutput("collide drain_done pulses", 32'(drainPulses), 0);
      checkOutput("collide tag_X", 32'(tag_X), 0);

      // Reset mid-drain after beat 5, then a clean full drain
      GON_valid = 1'b1; GON_ready = 1'b1; drain_start = 1'b1;
      applyStimulus();
      drain_start = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("mid tag_X after 5 beats", 32'(tag_X), 1);
      checkOutput("mid tag_Y after 5 beats", 32'(tag_Y), 0);
      rst = 1'b1;
      applyStimulus();
      rst = 1'b0;
      checkAllZero("mid reset");
      drainPulses = 0;
      for (int i = 0; i < 12; i++) begin
         applyStimulus();
         if (drain_done) drainPulses++;
      end
      checkOutput("mid no drain_done", 32'(drainPulses), 0);
      drain_start = 1'b1;
      applyStimulus();
      drain_start = 1'b0;
      for (int i = 0; i < 11; i++) applyStimulus();
      checkOutput("redrain beat11 drain_done", 32'(drain_done), 0);
      checkOutput("redrain beat11 tag_X", 32'(tag_X), 1);
      checkOutput("redrain beat11 tag_Y", 32'(tag_Y), 1);
      applyStimulus();
      checkOutput("redrain drain_done", 32'(drain_done), 1);
      GON_valid = 1'b0; GON_ready = 1'b0;
      applyStimulus();
      checkOutput("redrain idle busy", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gon_sequencer.md
# gon_sequencer

Controller for the Global Output Network (GON) gather path. It runs in two phases. First it configures the GON by shifting ID streams into the X and Y ID scan chains. Then it drains partial sums from the PE array to the GLB by stepping `tag_Y`/`tag_X` through the active rows and columns and counting beats accepted at the GON→GLB handshake. It sits between the top-level controller and the GON.

## Interface
Parameters:
- `X_SCAN_LEN`, default `` `NUMS_PE_ROW*`NUMS_PE_COL ``: number of XID shifts per configuration.
- `Y_SCAN_LEN`, default `` `NUMS_PE_ROW ``: number of YID shifts per configuration.
- `BEAT_W`, default 16: width of the per-tag beat count.

Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `cfg_start` input 1: pulse that starts the configuration phase.
- `xid_valid` input 1, `xid_ready` output 1, `xid_data` input `XID_BITS`: XID stream.
- `yid_valid` input 1, `yid_ready` output 1, `yid_data` input `YID_BITS`: YID stream.
- `set_XID` output 1, `XID_scan_in` output `XID_BITS`: X chain shift to the GON.
- `set_YID` output 1, `YID_scan_in` output `YID_BITS`: Y chain shift to the GON.
- `drain_start` input 1: pulse that starts the drain phase.
- `num_x` input `XID_BITS+1`, `num_y` input `YID_BITS+1`, `beats` input `BEAT_W`: drain extent. Sampled on `drain_start`.
- `tag_X` output `XID_BITS`, `tag_Y` output `YID_BITS`: tags to the GON.
- `GON_valid` input 1, `GON_ready` input 1: monitored copy of the GON→GLB handshake.
- `busy` output 1: high in CFG or DRAIN.
- `cfg_done` output 1, `drain_done` output 1: one-cycle completion pulses.

## Operation
FSM states: IDLE, CFG, DRAIN, DONE.

- **IDLE**
  - `cfg_start` → CFG, clearing `x_cnt`/`y_cnt`.
  - `drain_start` → DRAIN, latching `num_x`/`num_y`/`beats` and clearing the tags and `beat_cnt`.
  - If both starts are asserted in the same cycle, `cfg_start` wins and `drain_start` is dropped.
  - Starts outside IDLE are ignored.
- **CFG**
  - `xid_ready` = `x_cnt < X_SCAN_LEN`; `yid_ready` = `y_cnt < Y_SCAN_LEN`. Both are combinational from registers.
  - The two streams are independent and may shift in the same cycle.
  - An accepted beat registers `set_*`=1 and `*_scan_in`=data for exactly one following cycle, and increments its count.
  - No accepted beat → `set_*`=0 next cycle, and `*_scan_in` holds its last value.
  - When both counts reach their lengths → DONE, and `cfg_done` pulses.
- **DRAIN**
  - A beat is a cycle with `GON_valid & GON_ready`. Each beat increments `beat_cnt`.
  - On the beat where `beat_cnt == beats-1`:
    - `beat_cnt` ← 0.
    - `tag_X` increments.
    - If `tag_X == num_x-1`: `tag_X` ← 0 and `tag_Y` increments instead.
    - If this was also the last tag (`tag_X == num_x-1`, `tag_Y == num_y-1`) → DONE, and `drain_done` pulses; tags hold.
  - Order is `tag_Y` outer, `tag_X` inner, both ascending from 0.
  - Tags never change except on the final beat of the current tag.
  - Zero extent: if any of `num_x`, `num_y`, `beats` is 0 at start → DONE directly with no tag activity, and `drain_done` pulses.
- **DONE**: one cycle → IDLE. Each `*_done` pulse is registered and aligned with the DONE state.

## Timing
- Reset values: every output is 0 (`set_*`, `*_scan_in`, tags, readies, `busy`, `*_done`). The FSM goes to IDLE and all counters are cleared.
- Reset mid-operation:
  - All outputs are 0 on the cycle after `rst` is sampled.
  - A partial scan is abandoned; the chain contents are undefined and a full re-configuration is required.
  - An interrupted drain does not pulse `drain_done`.
- Latencies:
  - `cfg_start` → `xid_ready`/`yid_ready` high: 1 cycle.
  - Accepted ID beat → `set_*`: 1 cycle.
  - `drain_start` → tags valid and beats counted: 1 cycle.
  - Final beat of a tag → new tag visible: next cycle.
- `busy` is a registered state decode. It falls in the DONE cycle.
- Minimum CFG duration is `max(X_SCAN_LEN, Y_SCAN_LEN)` cycles, plus 1 cycle in DONE.
- Tag arithmetic:
  - Tags are compared against `num_* - 1` at full width; there is no wrap beyond `num_*`.
  - `num_x` greater than 2^`XID_BITS` is illegal.
  - `beats` is unsigned, with a maximum of 2^`BEAT_W`-1.

## Structure
- Shared package `gon_seq_pkg` holds:
  - the FSM state enum (`GS_IDLE`, `GS_CFG`, `GS_DRAIN`, `GS_DONE`);
  - `BEAT_W_DEFAULT`.
- `XID_BITS`, `YID_BITS`, `NUMS_PE_ROW` and `NUMS_PE_COL` come from the existing global defines.
- One sub-module: `gon_id_shifter`, instantiated twice (X and Y). It contains the stream ready logic, the shift counter, and the registered `set`/`scan_in` outputs.

## Test plan
- **Reset:** assert `rst` for 2 cycles → every output 0, state IDLE.
- **Configuration with stalls:** `X_SCAN_LEN`=4, `Y_SCAN_LEN`=2, IDs 1..4 and 0..1, with xid bubbles on alternate cycles.
  - `set_XID` is high on exactly 4 cycles with data 1,2,3,4.
  - `set_YID` is high on 2 cycles.
  - `cfg_done` pulses once, on the cycle after the last shift.
- **Drain with backpressure:** `num_x`=2, `num_y`=2, `beats`=3, random `GON_ready`.
  - Tag sequence is (0,0)→(1,0)→(0,1)→(1,1), each tag held for exactly 3 beats.
  - `drain_done` pulses after beat 12.
- **Zero extent:** `drain_start` with `beats`=0 → `drain_done` 2 cycles after start; `tag_X`/`tag_Y` stay 0.
- **Simultaneous starts:** `cfg_start` and `drain_start` in the same cycle → CFG entered, the drain is ignored, `drain_done` never pulses.
- **Reset mid-drain:** `rst` after beat 5 of 12 → IDLE next cycle, tags 0, no `drain_done`. A subsequent full drain completes normally.
